// File: rtl/half_adder_reg.sv
// rtl/half_adder_reg.sv - registered lane-parallel half adder, one-cycle latency
// Optional carry-event counter enabled by HALF_ADDER_REG_CARRY_COUNT_EN.
module half_adder_reg #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic             carry_any
`ifdef HALF_ADDER_REG_CARRY_COUNT_EN
    ,
    output logic [CNT_W-1:0] carry_count
`endif
);

    generate
        if ((WIDTH < 1) || (CNT_W < 1)) begin : g_bad_param
            $error("half_adder_reg: WIDTH and CNT_W must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic             r_carry_any;

    assign w_sum   = a ^ b;
    assign w_carry = a & b;

    // Results only load on accepted samples, so X on a/b with in_valid low is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_carry_any <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum       <= w_sum;
                r_carry     <= w_carry;
                r_carry_any <= |w_carry;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign carry_any = r_carry_any;

`ifdef HALF_ADDER_REG_CARRY_COUNT_EN
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [PC_W-1:0]  w_popcnt;
    logic [SUM_W-1:0] w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_carry_count;

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + PC_W'(w_carry[i]);
        end
    end

    // Sum in a wider word so overflow is visible, then clamp at all-ones.
    always_comb begin
        w_cnt_sum  = SUM_W'(r_carry_count) + SUM_W'(w_popcnt);
        w_cnt_next = r_carry_count;
        if (w_cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
            w_cnt_next = {CNT_W{1'b1}};
        end else begin
            w_cnt_next = w_cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_count <= '0;
        end else if (in_valid) begin
            r_carry_count <= w_cnt_next;
        end
    end

    assign carry_count = r_carry_count;
`endif

endmodule

// File: tb/tb_half_adder_reg.sv
// tb/tb_half_adder_reg.sv - scoreboard bench for half_adder_reg (WIDTH=1 and WIDTH=4)
module tb_half_adder_reg;

    logic       clk;
    logic       rst;
    logic       v1, a1, b1;
    logic       ov1, s1, c1, any1;
    logic       v4;
    logic [3:0] a4, b4;
    logic       ov4, any4;
    logic [3:0] s4, c4;
`ifdef HALF_ADDER_REG_CARRY_COUNT_EN
    logic [15:0] cnt1, cnt4;
    logic        ovc, anyc;
    logic [3:0]  sc, cc;
    logic [2:0]  cntc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] c;
        logic       any;
    } exp4_t;

    typedef struct packed {
        logic s;
        logic c;
    } exp1_t;

    exp4_t q4[$];
    exp1_t q1[$];

    half_adder_reg #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
        .out_valid(ov1), .sum(s1), .carry(c1), .carry_any(any1)
`ifdef HALF_ADDER_REG_CARRY_COUNT_EN
        , .carry_count(cnt1)
`endif
    );

    half_adder_reg #(.WIDTH(4), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4),
        .out_valid(ov4), .sum(s4), .carry(c4), .carry_any(any4)
`ifdef HALF_ADDER_REG_CARRY_COUNT_EN
        , .carry_count(cnt4)
`endif
    );

`ifdef HALF_ADDER_REG_CARRY_COUNT_EN
    half_adder_reg #(.WIDTH(4), .CNT_W(3)) u_cnt (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4),
        .out_valid(ovc), .sum(sc), .carry(cc), .carry_any(anyc),
        .carry_count(cntc)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        v1 = 1'b0; v4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q1.delete();
        q4.delete();
    endtask

    // Drive u4 at negedge, scoreboard push on accept, check #1 after posedge.
    task automatic step4(input logic v, input logic [3:0] a, input logic [3:0] b);
        exp4_t e;
        @(negedge clk);
        v4 = v; a4 = a; b4 = b;
        if (v) q4.push_back('{s: a ^ b, c: a & b, any: |(a & b)});
        @(posedge clk);
        #1;
        n_checks++;
        if (ov4 !== v) begin
            n_fail++;
            $display("FAIL out_valid4: got %b want %b", ov4, v);
        end
        if (v) begin
            e = q4.pop_front();
            n_checks++;
            if (s4 !== e.s || c4 !== e.c || any4 !== e.any) begin
                n_fail++;
                $display("FAIL result4: got s=%b c=%b any=%b want s=%b c=%b any=%b",
                         s4, c4, any4, e.s, e.c, e.any);
            end
            n_checks++;
            if ((s4 & c4) !== 4'b0000) begin
                n_fail++;
                $display("FAIL invariant4: got sum&carry=%b want 0000", s4 & c4);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ov1, s1, c1, any1, ov4, s4, c4, any4} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 0", {ov1, s1, c1, any1, ov4, s4, c4, any4});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_width1();
        logic [1:0] ab;
        exp1_t e;
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            @(negedge clk);
            v1 = 1'b1; a1 = ab[1]; b1 = ab[0];
            q1.push_back('{s: ab[1] ^ ab[0], c: ab[1] & ab[0]});
            @(posedge clk);
            #1;
            e = q1.pop_front();
            n_checks++;
            if (ov1 !== 1'b1 || s1 !== e.s || c1 !== e.c) begin
                n_fail++;
                $display("FAIL width1_ab%0d: got v=%b s=%b c=%b want v=1 s=%b c=%b",
                         i, ov1, s1, c1, e.s, e.c);
            end
        end
    endtask

    task automatic test_async_reset();
        // {a,b}=11 was just registered by test_width1; reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ov1, s1, c1, any1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b s=%b c=%b any=%b want all 0", ov1, s1, c1, any1);
        end
        @(negedge clk);
        v1 = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_lanes();
        step4(1'b1, 4'b1100, 4'b1010);
        n_checks++;
        if (s4 !== 4'b0110 || c4 !== 4'b1000 || any4 !== 1'b1) begin
            n_fail++;
            $display("FAIL lanes_a: got s=%b c=%b any=%b want s=0110 c=1000 any=1", s4, c4, any4);
        end
        step4(1'b1, 4'b0101, 4'b1010);
        n_checks++;
        if (s4 !== 4'b1111 || c4 !== 4'b0000 || any4 !== 1'b0) begin
            n_fail++;
            $display("FAIL lanes_b: got s=%b c=%b any=%b want s=1111 c=0000 any=0", s4, c4, any4);
        end
    endtask

    task automatic test_hold();
        step4(1'b1, 4'b0001, 4'b0000);
        step4(1'b0, 4'b0001, 4'b0001);
        n_checks++;
        if (s4 !== 4'b0001 || c4 !== 4'b0000 || any4 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got s=%b c=%b any=%b want s=0001 c=0000 any=0", s4, c4, any4);
        end
        step4(1'b0, 4'bxxxx, 4'bzzzz);
        n_checks++;
        if (s4 !== 4'b0001 || c4 !== 4'b0000 || any4 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_x: got s=%b c=%b any=%b want s=0001 c=0000 any=0", s4, c4, any4);
        end
    endtask

    task automatic test_random();
        logic [3:0] ra, rb;
        logic       rv;
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rv = 1'($urandom_range(0, 1));
            step4(rv, ra, rb);
        end
        n_checks++;
        if (q4.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d pending want 0", q4.size());
        end
    endtask

`ifdef HALF_ADDER_REG_CARRY_COUNT_EN
    task automatic test_carry_count();
        logic [2:0] want [3];
        want[0] = 3'd4; want[1] = 3'd7; want[2] = 3'd7;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step4(1'b1, 4'b1111, 4'b1111);
            n_checks++;
            if (cntc !== want[i]) begin
                n_fail++;
                $display("FAIL carry_count_%0d: got %0d want %0d", i, cntc, want[i]);
            end
        end
        @(negedge clk);
        v4 = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (cntc !== 3'd0) begin
            n_fail++;
            $display("FAIL carry_count_rst: got %0d want 0", cntc);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        v4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
        do_reset();
        test_reset();
        test_width1();
        test_async_reset();
        do_reset();
        test_lanes();
        test_hold();
        test_random();
`ifdef HALF_ADDER_REG_CARRY_COUNT_EN
        test_carry_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
